alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 35 +++
 rtl/alu_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU function codes, requester ids and output-stage states
package alu_arbiter_pkg;
  localparam int W = 64;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_func_e;
  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: 64-bit combinational ALU with signed/unsigned comparator flags
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_func_e    func,
  input  logic         sub_sra,
  output logic [W-1:0] s,
  output logic         eq,
  output logic         ls,
  output logic         lu
);
  logic [W-1:0] sum, sr;
  // result select; sub_sra turns add into subtract and logical into arithmetic right shift
  always_comb begin
    sum = sub_sra ? a - b : a + b;
    sr  = sub_sra ? W'($signed(a) >>> b[5:0]) : a >> b[5:0];
    eq  = a == b;
    lu  = a < b;
    ls  = $signed(a) < $signed(b);
    s   = '0;
    case (func)
      ALU_ADD:  s = sum;
      ALU_SLL:  s = a << b[5:0];
      ALU_SLT:  s = {{(W-1){1'b0}}, ls};
      ALU_SLTU: s = {{(W-1){1'b0}}, lu};
      ALU_XOR:  s = a ^ b;
      ALU_SR:   s = sr;
      ALU_OR:   s = a | b;
      ALU_AND:  s = a & b;
      default:  s = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU behind a 1-deep registered output; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         v0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   func0,
  input  logic         sub_sra0,
  output logic         rdy0,
  input  logic         v1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   func1,
  input  logic         sub_sra1,
  output logic         rdy1,
  input  logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] s,
  output logic         eq,
  output logic         ls,
  output logic         lu,
  output logic         o_id
);
  ostate_e state_q, state_d;
  logic accept_en, g0, g1, xfer, sel;
  logic [W-1:0] alu_a, alu_b, alu_s, s_q, s_d;
  alu_func_e alu_f;
  logic alu_sub, alu_eq, alu_ls, alu_lu;
  logic eq_q, eq_d, ls_q, ls_d, lu_q, lu_d, id_q, id_d;
`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;
  // pointer remembers the last granted id so the other requester wins the next contention
  always_comb ptr_d = xfer ? sel : ptr_q;
  // pointer register; reset value makes requester 0 win first
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= ID1;
    else ptr_q <= ptr_d;
  // requester 1 wins when alone or when requester 0 was granted last
  always_comb g1 = v1 && (!v0 || ptr_q == ID0);
`else
  // requester 0 always wins contention
  always_comb g1 = v1 && !v0;
`endif
  // grant, handshake and operand mux into the shared ALU
  always_comb begin
    g0        = v0 && !g1;
    accept_en = state_q == EMPTY || o_ready;
    rdy0      = accept_en && g0;
    rdy1      = accept_en && g1;
    xfer      = rdy0 || rdy1;
    sel       = g1 ? ID1 : ID0;
    alu_a     = g1 ? a1 : a0;
    alu_b     = g1 ? b1 : b0;
    alu_f     = alu_func_e'(g1 ? func1 : func0);
    alu_sub   = g1 ? sub_sra1 : sub_sra0;
  end
  alu_arbiter_alu u_alu (
    .a(alu_a), .b(alu_b), .func(alu_f), .sub_sra(alu_sub),
    .s(alu_s), .eq(alu_eq), .ls(alu_ls), .lu(alu_lu)
  );
  // output-stage next state: load on transfer, empty on drain, otherwise hold
  always_comb state_d = xfer ? FULL : o_ready ? EMPTY : state_q;
  // result capture on transfer, hold otherwise
  always_comb begin
    s_d  = xfer ? alu_s : s_q;
    eq_d = xfer ? alu_eq : eq_q;
    ls_d = xfer ? alu_ls : ls_q;
    lu_d = xfer ? alu_lu : lu_q;
    id_d = xfer ? sel : id_q;
  end
  // state and result registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      s_q     <= '0;
      eq_q    <= 1'b0;
      ls_q    <= 1'b0;
      lu_q    <= 1'b0;
      id_q    <= ID0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      eq_q    <= eq_d;
      ls_q    <= ls_d;
      lu_q    <= lu_d;
      id_q    <= id_d;
    end
  // outputs decoded from the registered stage
  always_comb begin
    o_valid = state_q == FULL;
    s       = s_q;
    eq      = eq_q;
    ls      = ls_q;
    lu      = lu_q;
    o_id    = id_q;
  end
endmodule
